// File: rtl/frame_assembler_mc.sv
// Packs CH_NUM sound channels and flight parameters into one frame per msec tick, double-banked.
// Optional build macro FRAME_HDR_EN prepends a {16'hFFFF, 8'h00, 4'h0, frame_cnt} header word.
module frame_assembler_mc #(
    parameter int CH_NUM      = 2,
    parameter int SAMPLES     = 500,
    parameter int PARAMS      = 12,
    parameter int PARAM_TOTAL = 48,
    parameter int AW          = 10
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start_en,
    input  logic                   tick,
    output logic [8:0]             snd_addr,
    input  logic [CH_NUM*16-1:0]   snd_q,
    output logic [7:0]             par_addr,
    input  logic [31:0]            par_q,
    output logic                   wr_en,
    output logic [AW:0]            wr_addr,
    output logic [31:0]            wr_data,
    output logic [1:0]             frame_rdy,
    input  logic [1:0]             tx_done,
    output logic [3:0]             frame_cnt,
    output logic                   overrun,
    output logic                   drop
);

    localparam int PAIRS = CH_NUM / 2;

    typedef enum logic [2:0] {
        S_ARM,
        S_WAIT,
        S_SND_RD,
        S_SND_WR,
        S_PAR_RD,
        S_PAR_WR,
        S_DONE
    } state_t;

    state_t          state;
    logic            tick_q;
    logic            tick_edge;
    logic            bank;
    logic [AW-1:0]   idx;
    logic [2:0]      pair;
    logic [7:0]      par_cnt;
    logic [31:0]     pair_word;

    assign tick_edge = tick & ~tick_q;

    // Pair k carries channels {2k+1, 2k}; snd_q holds steady while snd_addr is unchanged.
    always_comb begin
        pair_word = '0;
        for (int k = 0; k < PAIRS; k++) begin
            if (pair == 3'(k))
                pair_word = snd_q[32*k +: 32];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_ARM;
            tick_q    <= 1'b0;
            bank      <= 1'b0;
            idx       <= '0;
            pair      <= '0;
            par_cnt   <= '0;
            snd_addr  <= '0;
            par_addr  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_rdy <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            tick_q  <= tick;
            wr_en   <= 1'b0;
            overrun <= 1'b0;
            drop    <= 1'b0;

            // A bank being completed this cycle stays full even if tx_done clears it.
            for (int b = 0; b < 2; b++) begin
                if (state == S_DONE && bank == 1'(b))
                    frame_rdy[b] <= 1'b1;
                else if (tx_done[b])
                    frame_rdy[b] <= 1'b0;
            end

            if (tick_edge && state != S_ARM && state != S_WAIT)
                overrun <= 1'b1;

            case (state)
                S_ARM: begin
                    if (start_en)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tick_edge) begin
                        if (!start_en) begin
                            state <= S_ARM;
                        end else if (frame_rdy[bank]) begin
                            drop <= 1'b1;
                        end else begin
                            snd_addr <= '0;
                            pair     <= '0;
                            par_cnt  <= '0;
                            state    <= S_SND_RD;
`ifdef FRAME_HDR_EN
                            wr_en    <= 1'b1;
                            wr_addr  <= {bank, {AW{1'b0}}};
                            wr_data  <= {16'hFFFF, 8'h00, 4'h0, frame_cnt};
                            idx      <= AW'(1);
`else
                            idx      <= '0;
`endif
                        end
                    end
                end
                S_SND_RD: state <= S_SND_WR;
                S_SND_WR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= {bank, idx};
                    wr_data <= pair_word;
                    idx     <= idx + 1'b1;
                    if (pair == 3'(PAIRS - 1)) begin
                        pair <= '0;
                        if (snd_addr == 9'(SAMPLES - 1)) begin
                            state <= S_PAR_RD;
                        end else begin
                            snd_addr <= snd_addr + 9'd1;
                            state    <= S_SND_RD;
                        end
                    end else begin
                        pair <= pair + 3'd1;
                    end
                end
                S_PAR_RD: state <= S_PAR_WR;
                S_PAR_WR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= {bank, idx};
                    wr_data <= par_q;
                    idx     <= idx + 1'b1;
                    // The flight table pointer wraps freely, including mid-frame.
                    if (par_addr == 8'(PARAM_TOTAL - 1))
                        par_addr <= '0;
                    else
                        par_addr <= par_addr + 8'd1;
                    if (par_cnt == 8'(PARAMS - 1)) begin
                        state <= S_DONE;
                    end else begin
                        par_cnt <= par_cnt + 8'd1;
                        state   <= S_PAR_RD;
                    end
                end
                S_DONE: begin
                    frame_cnt <= frame_cnt + 4'd1;
                    bank      <= ~bank;
                    state     <= start_en ? S_WAIT : S_ARM;
                end
                default: state <= S_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_assembler_mc.sv
// Directed bench for frame_assembler_mc: default 2-channel instance plus a small 4-channel one.
module tb_frame_assembler_mc;

    localparam int AW  = 10;
    localparam int AW4 = 4;
`ifdef FRAME_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int FW  = 512 + HDR;
    localparam int FW4 = 8 + HDR;

    logic          clock;
    logic          reset_n;
    logic          start_en;
    logic          tick;
    logic          tick4;
    logic [8:0]    snd_addr,  snd_addr4;
    logic [31:0]   snd_q;
    logic [63:0]   snd_q4;
    logic [7:0]    par_addr,  par_addr4;
    logic [31:0]   par_q,     par_q4;
    logic          wr_en,     wr_en4;
    logic [AW:0]   wr_addr;
    logic [AW4:0]  wr_addr4;
    logic [31:0]   wr_data,   wr_data4;
    logic [1:0]    frame_rdy, frame_rdy4;
    logic [1:0]    tx_done,   tx_done4;
    logic [3:0]    frame_cnt, frame_cnt4;
    logic          overrun,   overrun4;
    logic          drop,      drop4;

    int pass = 0;
    int chk  = 0;

    frame_assembler_mc dut (
        .clock(clock), .reset_n(reset_n), .start_en(start_en), .tick(tick),
        .snd_addr(snd_addr), .snd_q(snd_q), .par_addr(par_addr), .par_q(par_q),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_rdy(frame_rdy),
        .tx_done(tx_done), .frame_cnt(frame_cnt), .overrun(overrun), .drop(drop)
    );

    frame_assembler_mc #(.CH_NUM(4), .SAMPLES(3), .PARAMS(2), .PARAM_TOTAL(5), .AW(AW4)) dut4 (
        .clock(clock), .reset_n(reset_n), .start_en(start_en), .tick(tick4),
        .snd_addr(snd_addr4), .snd_q(snd_q4), .par_addr(par_addr4), .par_q(par_q4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .frame_rdy(frame_rdy4),
        .tx_done(tx_done4), .frame_cnt(frame_cnt4), .overrun(overrun4), .drop(drop4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Sample value: channel in the top nibble, sample index below.
    function automatic logic [15:0] smp(input int s, input int c);
        return 16'((c << 12) | s);
    endfunction

    always @(posedge clock) begin
        snd_q  <= {smp(int'(snd_addr), 1), smp(int'(snd_addr), 0)};
        par_q  <= 32'hA500_0000 | 32'(par_addr);
        snd_q4 <= {smp(int'(snd_addr4), 3), smp(int'(snd_addr4), 2),
                   smp(int'(snd_addr4), 1), smp(int'(snd_addr4), 0)};
        par_q4 <= 32'hA500_0000 | 32'(par_addr4);
    end

    logic [31:0] cap  [0:2047];
    logic [31:0] cap4 [0:31];
    int wr_cnt = 0, wr_cnt4 = 0, seq_err = 0, last_idx = 0, ovr_cnt = 0, drop_cnt = 0;
    logic [AW:0] last_addr = '0;

    always @(negedge clock) begin
        if (wr_en) begin
            cap[wr_addr] <= wr_data;
            wr_cnt       <= wr_cnt + 1;
            if (wr_addr[AW-1:0] != 0 && int'(wr_addr[AW-1:0]) != last_idx + 1)
                seq_err <= seq_err + 1;
            last_idx  <= int'(wr_addr[AW-1:0]);
            last_addr <= wr_addr;
        end
        if (wr_en4) begin
            cap4[wr_addr4] <= wr_data4;
            wr_cnt4        <= wr_cnt4 + 1;
        end
        if (overrun) ovr_cnt  <= ovr_cnt + 1;
        if (drop)    drop_cnt <= drop_cnt + 1;
    end

    task automatic pulse_tick(input bit four);
        @(posedge clock); #1;
        if (four) tick4 = 1'b1; else tick = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        if (four) tick4 = 1'b0; else tick = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic pulse_tx(input logic [1:0] m, input bit four);
        @(posedge clock); #1;
        if (four) tx_done4 = m; else tx_done = m;
        @(posedge clock); #1;
        tx_done = 2'b00;
        tx_done4 = 2'b00;
        @(negedge clock);
    endtask

    task automatic wait_frame(input bit four, input logic [3:0] c0, input string name);
        int n = 0;
        while (((four ? frame_cnt4 : frame_cnt) == c0) && n < 4000) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk++;
        if (n >= 4000) $display("FAIL %s_timeout: waited %0d cycles, frame_cnt never advanced", name, n);
        else pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start_en = 1'b0; tick = 1'b0; tick4 = 1'b0;
        tx_done = 2'b00; tx_done4 = 2'b00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk++; if ({wr_en, overrun, drop, frame_rdy, frame_cnt} !== 9'd0)
            $display("FAIL reset_ctrl: got %b want 0", {wr_en, overrun, drop, frame_rdy, frame_cnt}); else pass++;
        chk++; if ({snd_addr, par_addr, wr_addr} !== 28'd0)
            $display("FAIL reset_addr: got %h want 0", {snd_addr, par_addr, wr_addr}); else pass++;
        chk++; if (wr_data !== 32'd0)
            $display("FAIL reset_data: got %h want 0", wr_data); else pass++;
        @(posedge clock); #1;
        reset_n = 1'b1; start_en = 1'b1;
        repeat (3) @(posedge clock);
    endtask

    task automatic test_single_frame();
        logic [3:0] c0 = frame_cnt;
        int w0 = wr_cnt;
        int s0 = seq_err;
        pulse_tick(0);
        wait_frame(0, c0, "t1");
        chk++; if (wr_cnt - w0 !== FW) $display("FAIL t1_words: got %0d want %0d", wr_cnt - w0, FW); else pass++;
        chk++; if (seq_err !== s0) $display("FAIL t1_contig: got %0d gaps want 0", seq_err - s0); else pass++;
        chk++; if (last_idx !== FW - 1) $display("FAIL t1_last_idx: got %0d want %0d", last_idx, FW - 1); else pass++;
        chk++; if (frame_rdy !== 2'b01) $display("FAIL t1_rdy: got %b want 01", frame_rdy); else pass++;
        chk++; if (frame_cnt !== 4'd1) $display("FAIL t1_cnt: got %0d want 1", frame_cnt); else pass++;
        chk++; if (cap[HDR] !== 32'h1000_0000) $display("FAIL t1_word0: got %h want 10000000", cap[HDR]); else pass++;
        chk++; if (cap[HDR+1] !== 32'h1001_0001) $display("FAIL t1_word1: got %h want 10010001", cap[HDR+1]); else pass++;
        chk++; if (cap[HDR+499] !== 32'h11F3_01F3) $display("FAIL t1_word499: got %h want 11f301f3", cap[HDR+499]); else pass++;
        chk++; if (cap[HDR+500] !== 32'hA500_0000) $display("FAIL t1_par0: got %h want a5000000", cap[HDR+500]); else pass++;
        chk++; if (cap[HDR+511] !== 32'hA500_000B) $display("FAIL t1_par11: got %h want a500000b", cap[HDR+511]); else pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] c0 = frame_cnt;
        int d0, w1;
        pulse_tick(0);
        wait_frame(0, c0, "t2a");
        chk++; if (frame_rdy !== 2'b11) $display("FAIL t2_rdy_both: got %b want 11", frame_rdy); else pass++;
        chk++; if (frame_cnt !== 4'd2) $display("FAIL t2_cnt: got %0d want 2", frame_cnt); else pass++;
        chk++; if (cap[1024+HDR] !== 32'h1000_0000) $display("FAIL t2_bank1_word0: got %h want 10000000", cap[1024+HDR]); else pass++;
        chk++; if (last_addr !== 11'(1024 + FW - 1)) $display("FAIL t2_bank1_last: got %h want %h", last_addr, 11'(1024 + FW - 1)); else pass++;
        d0 = drop_cnt; w1 = wr_cnt;
        pulse_tick(0);
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk++; if (drop_cnt - d0 !== 1) $display("FAIL t2_drop: got %0d pulses want 1", drop_cnt - d0); else pass++;
        chk++; if (frame_cnt !== 4'd2) $display("FAIL t2_drop_cnt: got %0d want 2", frame_cnt); else pass++;
        chk++; if (wr_cnt !== w1) $display("FAIL t2_drop_nowrite: got %0d writes want 0", wr_cnt - w1); else pass++;
        pulse_tx(2'b01, 0);
        chk++; if (frame_rdy !== 2'b10) $display("FAIL t2_tx_clear: got %b want 10", frame_rdy); else pass++;
        c0 = frame_cnt;
        pulse_tick(0);
        wait_frame(0, c0, "t2b");
        chk++; if (frame_cnt !== 4'd3) $display("FAIL t2_refill_cnt: got %0d want 3", frame_cnt); else pass++;
        chk++; if (last_addr !== 11'(FW - 1)) $display("FAIL t2_refill_bank0: got %h want %h", last_addr, 11'(FW - 1)); else pass++;
        pulse_tx(2'b11, 0);
        chk++; if (frame_rdy !== 2'b00) $display("FAIL t2_clear_all: got %b want 00", frame_rdy); else pass++;
    endtask

    task automatic test_overrun();
        logic [3:0] c0 = frame_cnt;
        int w0 = wr_cnt;
        int o0 = ovr_cnt;
        pulse_tick(0);
        repeat (100) @(posedge clock);
        pulse_tick(0);
        wait_frame(0, c0, "t3");
        chk++; if (ovr_cnt - o0 !== 1) $display("FAIL t3_overrun: got %0d pulses want 1", ovr_cnt - o0); else pass++;
        chk++; if (wr_cnt - w0 !== FW) $display("FAIL t3_words: got %0d want %0d", wr_cnt - w0, FW); else pass++;
        chk++; if (frame_cnt !== 4'd4) $display("FAIL t3_cnt: got %0d want 4", frame_cnt); else pass++;
        chk++; if (frame_rdy !== 2'b10) $display("FAIL t3_rdy: got %b want 10", frame_rdy); else pass++;
    endtask

    task automatic test_set_wins();
        int n = 0;
        pulse_tick(0);
        do begin
            @(negedge clock);
            n++;
        end while (!(wr_en && int'(wr_addr[AW-1:0]) == FW - 1) && n < 3000);
        chk++; if (n >= 3000) $display("FAIL sw_timeout: last word not seen after %0d cycles", n); else pass++;
        tx_done = 2'b01;
        @(posedge clock); #1;
        tx_done = 2'b00;
        @(negedge clock);
        chk++; if (frame_rdy !== 2'b11) $display("FAIL sw_set_wins: got %b want 11", frame_rdy); else pass++;
        chk++; if (frame_cnt !== 4'd5) $display("FAIL sw_cnt: got %0d want 5", frame_cnt); else pass++;
    endtask

    task automatic test_param_wrap();
        chk++; if (par_addr !== 8'd12) $display("FAIL t4_par_start: got %0d want 12", par_addr); else pass++;
        pulse_tx(2'b11, 0);
        for (int f = 0; f < 4; f++) begin
            int b = (f % 2 == 0) ? 1024 : 0;
            logic [3:0] c0 = frame_cnt;
            pulse_tick(0);
            wait_frame(0, c0, "t4");
            chk++; if (cap[b+HDR+500] !== (32'hA500_0000 | 32'((12 + 12*f) % 48)))
                $display("FAIL t4_first_par f%0d: got %h want %h", f, cap[b+HDR+500], 32'hA500_0000 | 32'((12 + 12*f) % 48)); else pass++;
            chk++; if (cap[b+HDR+511] !== (32'hA500_0000 | 32'((23 + 12*f) % 48)))
                $display("FAIL t4_last_par f%0d: got %h want %h", f, cap[b+HDR+511], 32'hA500_0000 | 32'((23 + 12*f) % 48)); else pass++;
            pulse_tx(2'b11, 0);
        end
        chk++; if (par_addr !== 8'd12) $display("FAIL t4_par_end: got %0d want 12", par_addr); else pass++;
        chk++; if (frame_cnt !== 4'd9) $display("FAIL t4_cnt: got %0d want 9", frame_cnt); else pass++;
    endtask

    task automatic test_ch4();
        logic [3:0] c0 = frame_cnt4;
        int w0 = wr_cnt4;
        pulse_tick(1);
        wait_frame(1, c0, "t5a");
        chk++; if (wr_cnt4 - w0 !== FW4) $display("FAIL t5_words: got %0d want %0d", wr_cnt4 - w0, FW4); else pass++;
        chk++; if (cap4[HDR] !== 32'h1000_0000) $display("FAIL t5_pair0: got %h want 10000000", cap4[HDR]); else pass++;
        chk++; if (cap4[HDR+1] !== 32'h3000_2000) $display("FAIL t5_pair1: got %h want 30002000", cap4[HDR+1]); else pass++;
        chk++; if (cap4[HDR+5] !== 32'h3002_2002) $display("FAIL t5_s2_pair1: got %h want 30022002", cap4[HDR+5]); else pass++;
        chk++; if (cap4[HDR+7] !== 32'hA500_0001) $display("FAIL t5_par1: got %h want a5000001", cap4[HDR+7]); else pass++;
        c0 = frame_cnt4;
        pulse_tick(1);
        wait_frame(1, c0, "t5b");
        chk++; if (cap4[16+HDR+6] !== 32'hA500_0002) $display("FAIL t5_bank1_par: got %h want a5000002", cap4[16+HDR+6]); else pass++;
        pulse_tx(2'b01, 1);
        c0 = frame_cnt4;
        pulse_tick(1);
        wait_frame(1, c0, "t5c");
        chk++; if (cap4[HDR+6] !== 32'hA500_0004) $display("FAIL t5_par4: got %h want a5000004", cap4[HDR+6]); else pass++;
        chk++; if (cap4[HDR+7] !== 32'hA500_0000) $display("FAIL t5_par_wrap: got %h want a5000000", cap4[HDR+7]); else pass++;
        chk++; if ({frame_rdy4, frame_cnt4} !== 6'b11_0011) $display("FAIL t5_rdy_cnt: got %b want 110011", {frame_rdy4, frame_cnt4}); else pass++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] exp0;
        int w0;
`ifdef FRAME_HDR_EN
        exp0 = 32'hFFFF_0000;
`else
        exp0 = 32'h1000_0000;
`endif
        pulse_tick(0);
        repeat (200) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk++; if ({wr_en, frame_rdy, frame_cnt, overrun, drop} !== 9'd0)
            $display("FAIL t6_abort_ctrl: got %b want 0", {wr_en, frame_rdy, frame_cnt, overrun, drop}); else pass++;
        chk++; if ({snd_addr, par_addr, wr_addr} !== 28'd0)
            $display("FAIL t6_abort_addr: got %h want 0", {snd_addr, par_addr, wr_addr}); else pass++;
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        w0 = wr_cnt;
        pulse_tick(0);
        wait_frame(0, 4'd0, "t6");
        chk++; if (cap[0] !== exp0) $display("FAIL t6_word0: got %h want %h", cap[0], exp0); else pass++;
        chk++; if (wr_cnt - w0 !== FW) $display("FAIL t6_words: got %0d want %0d", wr_cnt - w0, FW); else pass++;
        chk++; if ({frame_rdy, frame_cnt} !== 6'b01_0001) $display("FAIL t6_rdy_cnt: got %b want 010001", {frame_rdy, frame_cnt}); else pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_set_wins();
        test_param_wrap();
        test_ch4();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
